// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Circular first-set-bit search over a request mask from a start index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         mask,
   input  logic [$clog2(NUM_REQ)-1:0] start,
   output logic                       found,
   output logic [$clog2(NUM_REQ)-1:0] idx
);

   localparam int c_TW = $clog2(NUM_REQ);

   int w_dist;
   int w_best;

   // Winner is the set bit with the smallest circular distance from start.
   always_comb begin
      found  = 1'b0;
      idx    = '0;
      w_best = NUM_REQ;
      w_dist = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_dist = (j >= int'(start)) ? (j - int'(start)) : (j + NUM_REQ - int'(start));
         if (mask[j] && (w_dist < w_best)) begin
            w_best = w_dist;
            found  = 1'b1;
            idx    = c_TW'(j);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rom_read_arbiter.sv
// ============================================================================
// Module   : rom_read_arbiter
// Purpose  : Round-robin sharing of a dual-port ROM's two read ports among requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_read_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 36
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
   output logic [ADDR_WIDTH-1:0]         rom_addr_a,
   output logic [ADDR_WIDTH-1:0]         rom_addr_b,
   input  logic [DATA_WIDTH-1:0]         rom_dout_a,
   input  logic [DATA_WIDTH-1:0]         rom_dout_b
);

   localparam int              c_TW   = $clog2(NUM_REQ);
   localparam logic [c_TW-1:0] c_LAST = c_TW'(NUM_REQ - 1);

   logic [c_TW-1:0]       r_ptr;
   logic [c_TW-1:0]       r_tag_a;
   logic [c_TW-1:0]       r_tag_b;
   logic                  r_busy_a;
   logic                  r_busy_b;
   logic [ADDR_WIDTH-1:0] r_hold_a;
   logic [ADDR_WIDTH-1:0] r_hold_b;

   logic [NUM_REQ-1:0] w_req;
   logic [NUM_REQ-1:0] w_mask_b;
   logic               w_found_a;
   logic               w_found_b;
   logic [c_TW-1:0]    w_idx_a;
   logic [c_TW-1:0]    w_idx_b;
   logic [c_TW-1:0]    w_start_b;
   logic [c_TW-1:0]    w_next_b;

   // No grants are offered while reset is held.
   assign w_req     = rst ? '0 : req_valid;
   assign w_start_b = (w_idx_a == c_LAST) ? '0 : w_idx_a + 1'b1;
   assign w_next_b  = (w_idx_b == c_LAST) ? '0 : w_idx_b + 1'b1;

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask_b
         assign w_mask_b[g] = w_req[g] && !(w_found_a && (w_idx_a == c_TW'(g)));
      end
   endgenerate

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_a (
      .mask  (w_req),
      .start (r_ptr),
      .found (w_found_a),
      .idx   (w_idx_a)
   );

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_b (
      .mask  (w_mask_b),
      .start (w_start_b),
      .found (w_found_b),
      .idx   (w_idx_b)
   );

   always_comb begin
      req_ready  = '0;
      rom_addr_a = r_hold_a;
      rom_addr_b = r_hold_b;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_found_a && (w_idx_a == c_TW'(j))) begin
            req_ready[j] = 1'b1;
            rom_addr_a   = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
         end
         if (w_found_b && (w_idx_b == c_TW'(j))) begin
            req_ready[j] = 1'b1;
            rom_addr_b   = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr    <= '0;
         r_tag_a  <= '0;
         r_tag_b  <= '0;
         r_busy_a <= 1'b0;
         r_busy_b <= 1'b0;
         r_hold_a <= '0;
         r_hold_b <= '0;
      end else begin
         r_busy_a <= w_found_a;
         r_busy_b <= w_found_b;
         r_hold_a <= rom_addr_a;
         r_hold_b <= rom_addr_b;
         if (w_found_a) r_tag_a <= w_idx_a;
         if (w_found_b) r_tag_b <= w_idx_b;
         if (w_found_b)      r_ptr <= w_next_b;
         else if (w_found_a) r_ptr <= w_start_b;
      end
   end

   // Tags never collide, so each lane sees at most one port.
   always_comb begin
      resp_valid = '0;
      resp_data  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!rst && r_busy_a && (r_tag_a == c_TW'(j))) begin
            resp_valid[j]                        = 1'b1;
            resp_data[j*DATA_WIDTH +: DATA_WIDTH] = rom_dout_a;
         end
         if (!rst && r_busy_b && (r_tag_b == c_TW'(j))) begin
            resp_valid[j]                        = 1'b1;
            resp_data[j*DATA_WIDTH +: DATA_WIDTH] = rom_dout_b;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Shares the two read ports of the dual-port ROM between `NUM_REQ` requesters on a single clock domain. Each cycle it grants up to two pending requests in round-robin order, one to port A and one to port B. It drives the ROM addresses and routes each registered ROM word back to the requester that issued it, one cycle later. It sits between the lookup-table consumers and the ROM instance, whose `clk_a`/`clk_b` are both tied to `clk`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ADDR_WIDTH`, 10: ROM address width.
- `DATA_WIDTH`, 36: ROM word width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester read request.
- `req_addr` in NUM_REQ*ADDR_WIDTH: flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready` out NUM_REQ: combinational grant. A request transfers when `req_valid[i] && req_ready[i]`.
- `resp_valid` out NUM_REQ: registered, one-cycle pulse per granted request.
- `resp_data` out NUM_REQ*DATA_WIDTH: flattened response words; lane i is valid only while `resp_valid[i]`.
- `rom_addr_a`, `rom_addr_b` out ADDR_WIDTH: to ROM `addr_a`/`addr_b`.
- `rom_dout_a`, `rom_dout_b` in DATA_WIDTH: from ROM `dout_a`/`dout_b`. The ROM registers these, with 1-cycle read latency.

## Operation
- State:
  - round-robin pointer `ptr` (width $clog2(NUM_REQ));
  - in-flight tags `tag_a`/`tag_b` (requester index) with `busy_a`/`busy_b` flags.
- Grant A: first i with `req_valid[i]`, searching circularly from `ptr`.
- Grant B: first valid requester circularly after grant A, excluding grant A.
- At most one grant per requester per cycle. With a single valid requester, only port A is used.
- `req_ready[i]` = (grant A == i) or (grant B == i). It is a pure function of `req_valid` and `ptr` and must not depend on `req_addr`.
- `rom_addr_a`/`rom_addr_b` = address of the port's granted requester. An idle port holds its previous address, with no spurious response.
- `ptr` update:
  - two grants: `ptr` ← (grant B + 1) mod NUM_REQ;
  - one grant: `ptr` ← (grant A + 1) mod NUM_REQ;
  - none: `ptr` unchanged.
  - Wrap from NUM_REQ-1 to 0.
- Next edge after a grant: `busy_x` ← 1, `tag_x` ← grantee index.
- Response cycle:
  - `resp_valid[tag_a]` = `busy_a`, with `resp_data` lane `tag_a` = `rom_dout_a`.
  - Same for B.
  - Tags never collide because grants are distinct.
- No response backpressure: requesters must accept `resp_valid` unconditionally. A requester may issue back-to-back requests every cycle.
- Fairness: any continuously asserted request is granted within ceil(NUM_REQ/2) cycles.

## Timing
- Reset values:
  - `ptr` = 0;
  - `busy_a` = `busy_b` = 0;
  - `resp_valid` = 0;
  - `resp_data` = 0;
  - `rom_addr_a` = `rom_addr_b` = 0.
- Grant at edge N: address is presented during cycle N and sampled by the ROM at edge N+1. `resp_valid` is high during cycle N+1 (after edge N+1), and the ROM word is valid in that cycle.
- The response pipeline is a registered tag only. `resp_data` lanes are muxed combinationally from `rom_dout_*` gated by the busy/tag match; non-selected lanes are 0.
- Reset mid-operation:
  - `busy_*` cleared, so in-flight reads are dropped.
  - No `resp_valid` in the cycle after reset deasserts.
  - While `rst` is high, `req_ready` = 0.
- Simultaneous events: a requester may be granted and receive a previous response in the same cycle; both proceed independently.

## Structure
- No shared package: all widths are parameters, and the tag width is a localparam from $clog2(NUM_REQ).
- One sub-module `rr_pick`:
  - inputs: NUM_REQ-bit request mask and start index;
  - outputs: found flag and index of the first set bit, searching circularly from start.
  - Instantiated twice: port A uses `req_valid` from `ptr`; port B uses `req_valid` with grant A masked off, starting at grant A + 1.

## Test plan
ROM preloaded with word[addr] = addr + 0x100. NUM_REQ = 4.
- Reset: assert `rst` 3 cycles with all `req_valid`=1 → `req_ready`=0, `resp_valid`=0, `ptr`=0 throughout.
- Single requester 2, addr 0x005 → `req_ready[2]` same cycle; next cycle `resp_valid`=4'b0100, lane 2 = 0x105; port B unused.
- All four valid continuously, addr i → grants {0,1}, {2,3}, {0,1} on successive cycles; each response carries 0x100+i.
- Requesters 3 and 0 valid with `ptr`=3 → A=3, B=0 (wrap); `ptr` becomes 1.
- Requester 1 back-to-back, addrs 0x3FF then 0x000 → responses 0x4FF then 0x100 on consecutive cycles.
- Reset asserted the cycle after granting {0,1} → no `resp_valid` at or after reset; first post-reset request served normally.
